// File: rtl/k16_text_renderer.sv
// K16 text/graphics pixel pipeline: VGA counters -> VRAM cell fetch -> font row fetch -> RGB.
// Fixed 5-clock latency from input sample to registered colour and delayed sync/enable.
module k16_text_renderer #(
    parameter int   COLS         = 40,
    parameter int   ROWS         = 30,
    parameter logic VSYNC_ACTIVE = 1'b0,
    parameter logic SYNC_IDLE    = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] vram_addr,
    input  logic [15:0] vram_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        red,
    output logic        green,
    output logic        blue,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out
);

    localparam logic [5:0]  COLS_W = 6'(COLS);
    localparam logic [5:0]  ROWS_W = 6'(ROWS);
    localparam logic [10:0] COLS_A = 11'(COLS);

    logic [5:0]  col;
    logic [5:0]  row;
    logic        in_range;
    logic [10:0] cell_addr;

    assign col       = h_cnt[9:4];
    assign row       = v_cnt[9:4];
    assign in_range  = (col < COLS_W) && (row < ROWS_W);
    assign cell_addr = 11'(row) * COLS_A + 11'(col);

    // Pixel-within-glyph bits are doubled, so the LSBs of the counters carry no information.
    logic unused_bits;
    assign unused_bits = ^{h_cnt[0], v_cnt[0]};

    // Side-band shift registers: index 0 is the E1 stage, index 3 the E4 stage.
    logic [3:0]       de_p;
    logic [3:0]       hs_p;
    logic [3:0]       vs_p;
    logic [3:0]       ir_p;
    logic [3:0][2:0]  gx_p;
    logic [3:0][1:0]  q_p;
    logic [2:0]       gr1;
    logic [2:0]       gr2;
    logic [15:0]      word3;
    logic [15:0]      word4;

    logic             vs_prev;
    logic [5:0]       frame_cnt;
    logic [2:0]       colour;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr <= '0;
            font_addr <= '0;
            de_p      <= '0;
            hs_p      <= {4{SYNC_IDLE}};
            vs_p      <= {4{SYNC_IDLE}};
            ir_p      <= '0;
            gx_p      <= '0;
            q_p       <= '0;
            gr1       <= '0;
            gr2       <= '0;
            word3     <= '0;
            word4     <= '0;
            red       <= 1'b0;
            green     <= 1'b0;
            blue      <= 1'b0;
            de_out    <= 1'b0;
            hsync_out <= SYNC_IDLE;
            vsync_out <= SYNC_IDLE;
        end else begin
            // Out-of-range cells keep the previous address; the pixel is blanked at E5.
            if (in_range)
                vram_addr <= cell_addr;
            de_p <= {de_p[2:0], de_in};
            hs_p <= {hs_p[2:0], hsync_in};
            vs_p <= {vs_p[2:0], vsync_in};
            ir_p <= {ir_p[2:0], in_range};
            gx_p <= {gx_p[2:0], h_cnt[3:1]};
            q_p  <= {q_p[2:0], {v_cnt[3], h_cnt[3]}};
            gr1  <= v_cnt[3:1];
            gr2  <= gr1;

            font_addr <= {vram_data[7:0], gr2};
            word3     <= vram_data;
            word4     <= word3;

            red       <= colour[2];
            green     <= colour[1];
            blue      <= colour[0];
            de_out    <= de_p[3];
            hsync_out <= hs_p[3];
            vsync_out <= vs_p[3];
        end
    end

    // Frame counter for blink: counts entries into the active vsync level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev   <= VSYNC_ACTIVE;
            frame_cnt <= '0;
        end else begin
            vs_prev <= vsync_in;
            if ((vsync_in == VSYNC_ACTIVE) && (vs_prev != VSYNC_ACTIVE))
                frame_cnt <= frame_cnt + 6'd1;
        end
    end

    logic [2:0] fg;
    logic [2:0] bg;
    logic       pix;

    assign fg  = word4[10:8];
    assign bg  = word4[13:11];
    assign pix = font_data[3'd7 - gx_p[3]];

    always_comb begin
        colour = 3'd0;
        if (de_p[3] && ir_p[3]) begin
            if (word4[15]) begin
                case (q_p[3])
                    2'd0:    colour = word4[2:0];
                    2'd1:    colour = word4[5:3];
                    2'd2:    colour = word4[8:6];
                    default: colour = word4[11:9];
                endcase
            end else if (word4[14] && frame_cnt[5]) begin
                colour = bg;
            end else begin
                colour = pix ? fg : bg;
            end
        end
    end

endmodule
